// File: rtl/lead_count_normalizer_if.sv
// Operand/result bus of lead_count_normalizer: valid/ready on both sides.
// The master drives operands and accepts results; the slave is the normaliser.
interface lead_count_normalizer_if #(
  parameter int N  = 32,
  parameter int CW = $clog2(N + 1)
) ();
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic [N-1:0]  norm;
  logic          zero;

  modport master (
    output in_valid, x, mode, out_ready,
    input  in_ready, out_valid, count, norm, zero
  );

  modport slave (
    input  in_valid, x, mode, out_ready,
    output in_ready, out_valid, count, norm, zero
  );
endinterface

// File: rtl/lead_count_normalizer.sv
// Two-stage pipelined leading-bit counter and normaliser with valid/ready.
// S1 holds the operand and its count, S2 holds count, shifted operand and zero flag.
// Optional feature macro: LCN_SIGNMODE_EN enables the redundant-sign-bit count
// selected by mode = 1; without it mode is ignored and every operand is counted
// as leading zeros.
module lead_count_normalizer #(
  parameter int N  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lead_count_normalizer_if.slave  bus
);

  logic [CW-1:0] lz_count;
  logic [CW-1:0] in_count;

  // Leading zeros: the highest set bit wins because later iterations overwrite.
  always_comb begin
    lz_count = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (bus.x[i]) lz_count = CW'(N - 1 - i);
    end
  end

`ifdef LCN_SIGNMODE_EN
  logic [CW-1:0] sb_count;

  // Redundant sign bits: the highest bit differing from the MSB sets the count.
  always_comb begin
    sb_count = CW'(N - 1);
    for (int i = 0; i < N - 1; i++) begin
      if (bus.x[i] != bus.x[N-1]) sb_count = CW'(N - 2 - i);
    end
  end

  // The count already carries the effect of mode, so mode needs no register.
  assign in_count = bus.mode ? sb_count : lz_count;
`else
  assign in_count = lz_count;
`endif

  logic          s1_valid;
  logic [N-1:0]  s1_x;
  logic [CW-1:0] s1_count;
  logic          s2_valid;
  logic [CW-1:0] s2_count;
  logic [N-1:0]  s2_norm;
  logic          s2_zero;
  logic          s2_load;
  logic          in_ready;
  logic          in_fire;

  // S2 takes new data when empty or when its result leaves this cycle.
  assign s2_load  = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = bus.in_valid && in_ready;

  // Stage 1: capture the operand and its combinational count on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_count <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_x     <= bus.x;
      s1_count <= in_count;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: barrel shift from the S1 registers; held while stalled.
  // A shift by N (all-zero operand) yields zero, which is the wanted norm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_count <= '0;
      s2_norm  <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_count <= s1_count;
        s2_norm  <= s1_x << s1_count;
        s2_zero  <= (s1_x == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.count     = s2_count;
  assign bus.norm      = s2_norm;
  assign bus.zero      = s2_zero;

endmodule

// File: tb/tb_lead_count_normalizer.sv
// Self-checking bench for lead_count_normalizer: directed cases plus random
// traffic against an arithmetic reference model and an in-order scoreboard.
module tb_lead_count_normalizer;
  localparam int N  = 32;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lead_count_normalizer_if #(.N(N)) bus ();
  lead_count_normalizer_if #(.N(8)) bus8 ();

  lead_count_normalizer #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  lead_count_normalizer #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [63:0] count;
    logic [63:0] norm;
    logic [63:0] zero;
  } result_t;

  result_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit last_in_fire;
  bit last_out_fire;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bit_length(input logic [63:0] v);
    int b = 0;
    while (v != 0) begin
      b++;
      v = v >> 1;
    end
    return b;
  endfunction

  // Reference: counts from the bit length of the operand (or its complement).
  function automatic result_t model(input logic [N-1:0] xv, input logic m);
    result_t r;
    int c;
    logic [N-1:0] inv;
    c = N - bit_length(64'(xv));
`ifdef LCN_SIGNMODE_EN
    if (m) begin
      inv = xv[N-1] ? ~xv : xv;
      c = N - 1 - bit_length(64'(inv));
    end
`else
    inv = '0;
    if (m && inv != '0) c = 0;
`endif
    r.count = 64'(c);
    r.norm  = 64'(N'(64'(xv) << c));
    r.zero  = 64'(xv == '0);
    return r;
  endfunction

  // One cycle: inputs already set at the falling edge; evaluate, then advance.
  task automatic step();
    result_t e;
    #1;
    last_in_fire  = bus.in_valid && bus.in_ready;
    last_out_fire = bus.out_valid && bus.out_ready;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q[0];
        check("count", 64'(bus.count), e.count);
        check("norm", 64'(bus.norm), e.norm);
        check("zero", 64'(bus.zero), e.zero);
        $display("out count=%0d norm=0x%08h zero=%0d ready=%0d", bus.count, bus.norm, bus.zero, bus.out_ready);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
    if (last_in_fire) exp_q.push_back(model(bus.x, bus.mode));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && k < max_cycles) begin
      step();
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [N-1:0] directed_x [4];
  logic         directed_m [4];
  int accepts;
  logic [31:0] r;
  int sh;

  initial begin
    bus.in_valid = 1'b0; bus.x = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.x = '0; bus8.mode = 1'b0; bus8.out_ready = 1'b1;
    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_norm", 64'(bus.norm), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: operand driven for one cycle, result visible after two edges.
    bus.in_valid = 1'b1; bus.x = 32'h0000_8000; bus.mode = 1'b0;
    step();
    bus.in_valid = 1'b0;
    #1 check("lat_edge1_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("lat_edge2_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_count16", 64'(bus.count), 64'd16);
    check("lat_norm", 64'(bus.norm), 64'h8000_0000);
    drain(10);

    // Directed corner operands.
    directed_x[0] = 32'h0000_0000; directed_m[0] = 1'b0;
    directed_x[1] = 32'hFFFF_F000; directed_m[1] = 1'b1;
    directed_x[2] = 32'hFFFF_FFFF; directed_m[2] = 1'b1;
    directed_x[3] = 32'h0000_0000; directed_m[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.x = directed_x[i]; bus.mode = directed_m[i];
      step();
    end
    drain(10);

    // Walking-ones stream: one result every cycle once the pipe is full.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1; bus.x = N'(64'd1 << i); bus.mode = 1'b0;
      step();
      check("stream_in_ready", 64'(last_in_fire), 64'd1);
      if (i >= 2) check("stream_no_bubble", 64'(last_out_fire), 64'd1);
    end
    drain(10);

    // Stall: only two operands fit, outputs held, then in-order drain.
    bus.out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.x = 32'h0100_0000 >> i; bus.mode = 1'b0;
      step();
      if (last_in_fire) accepts++;
    end
    check("stall_accepts", 64'(accepts), 64'd2);
    #1 check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    drain(10);

    // Random traffic with random handshakes.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      sh = $urandom_range(0, 32);
      bus.x = (sh == 32) ? '0 : N'(r >> sh);
      if ($urandom_range(0, 1) == 1) bus.x = ~bus.x;
      bus.mode      = 1'($urandom_range(0, 1));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(10);

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.x = 32'h0000_0F00 << i; bus.mode = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    #1 check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_count", 64'(bus.count), 64'd0);
    check("async_rst_norm", 64'(bus.norm), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    end

    // Narrow instance: all-zero operand gives the full count on 4 bits.
    bus8.in_valid = 1'b1; bus8.x = '0; bus8.mode = 1'b0;
    @(posedge clk); @(negedge clk);
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    check("n8_out_valid", 64'(bus8.out_valid), 64'd1);
    check("n8_count", 64'(bus8.count), 64'd8);
    check("n8_zero", 64'(bus8.zero), 64'd1);
    check("n8_norm", 64'(bus8.norm), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
